music_player: RTL and testbench

Sequencer and tone generator that sits directly downstream of the note ROMs (`music1`/`music2`/`music3`). It steps the ROM address through the song and captures each 20-bit half-period word, counted in 50 MHz clocks. It then drives a square wave on the speaker pin for a fixed note duration, with a short silent gap after each note so repeated notes stay distinct. A single play can run once or loop, and can be aborted at any time.

---
 rtl/music_player.sv | 157 +++++++++++++++
 tb/tb_music_player.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// Note sequencer and square-wave tone generator fed by a registered-output note ROM.
// Each slot is FETCH, LOAD, PLAY and GAP; a play ends after the last address or loops to 0.
module music_player #(
    parameter int unsigned NUM_NOTES  = 31,
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [4:0]  rom_addr,
    input  logic [19:0] rom_data,
    output logic        speaker,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StGap,
        StFinish
    } state_e;

    localparam logic [4:0]  LastAddr = 5'(NUM_NOTES - 1);
    localparam logic [23:0] PlayLast = 24'(NOTE_TICKS - GAP_TICKS - 1);
    localparam logic [23:0] SlotLast = 24'(NOTE_TICKS - 1);
    localparam bit          HasGap   = (GAP_TICKS != 0);

    state_e      state_q, state_d;
    logic [4:0]  rom_addr_q, rom_addr_d;
    logic        speaker_q, speaker_d;
    logic [19:0] half_period_q, half_period_d;
    logic [19:0] tone_cnt_q, tone_cnt_d;
    logic [23:0] note_cnt_q, note_cnt_d;

    logic        play_end;
    logic        slot_end;
    logic        last_note;
    logic        tone_wrap;
    logic [4:0]  next_addr;
    state_e      adv_state;

    // note_cnt runs across PLAY and GAP so one counter times the whole slot
    assign play_end  = (state_q == StPlay) && (note_cnt_q == PlayLast);
    assign slot_end  = HasGap ? ((state_q == StGap) && (note_cnt_q == SlotLast)) : play_end;
    assign last_note = (rom_addr_q == LastAddr);
    assign tone_wrap = (tone_cnt_q == half_period_q - 20'd1);
    assign adv_state = (last_note && !loop) ? StFinish : StFetch;

    always_comb begin
        next_addr = rom_addr_q + 5'd1;
        if (last_note) begin
            next_addr = loop ? 5'd0 : rom_addr_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rom_addr_q    <= 5'd0;
            speaker_q     <= 1'b0;
            half_period_q <= 20'd0;
            tone_cnt_q    <= 20'd0;
            note_cnt_q    <= 24'd0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            speaker_q     <= speaker_d;
            half_period_q <= half_period_d;
            tone_cnt_q    <= tone_cnt_d;
            note_cnt_q    <= note_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start) state_d = StFetch;
                StFetch:  state_d = StLoad;
                StLoad:   state_d = StPlay;
                StPlay: begin
                    if (play_end) begin
                        state_d = HasGap ? StGap : adv_state;
                    end
                end
                StGap:    if (slot_end) state_d = adv_state;
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Datapath next values; speaker defaults low so every non-PLAY state is silent
    always_comb begin
        rom_addr_d    = rom_addr_q;
        speaker_d     = 1'b0;
        half_period_d = half_period_q;
        tone_cnt_d    = tone_cnt_q;
        note_cnt_d    = note_cnt_q;
        if (stop) begin
            rom_addr_d = 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) rom_addr_d = 5'd0;
                end
                StLoad: begin
                    half_period_d = rom_data;
                    tone_cnt_d    = 20'd0;
                    note_cnt_d    = 24'd0;
                end
                StPlay: begin
                    note_cnt_d = note_cnt_q + 24'd1;
                    if (!play_end) begin
                        if (half_period_q == 20'd0) begin
                            tone_cnt_d = 20'd0;
                        end else if (tone_wrap) begin
                            tone_cnt_d = 20'd0;
                            speaker_d  = ~speaker_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + 20'd1;
                            speaker_d  = speaker_q;
                        end
                    end
                    if (slot_end) rom_addr_d = next_addr;
                end
                StGap: begin
                    note_cnt_d = note_cnt_q + 24'd1;
                    if (slot_end) rom_addr_d = next_addr;
                end
                StFinish: begin
                    rom_addr_d = 5'd0;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rom_addr = rom_addr_q;
        speaker  = speaker_q;
        busy     = (state_q != StIdle);
        done     = (state_q == StFinish);
    end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player: 3-note ROM {3, 0, 1}, 20-tick slots with and without a gap.
module tb_music_player;

    localparam int Slot     = 22;
    localparam int PlayLen  = 16;
    localparam int PlayLen2 = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [4:0]  rom_addr;
    logic [19:0] rom_data = '0;
    logic        speaker, busy, done;

    logic        start_ng = 1'b0, loop_ng = 1'b0;
    logic [4:0]  rom_addr_ng;
    logic [19:0] rom_data_ng = '0;
    logic        speaker_ng, busy_ng, done_ng;

    int errors = 0;
    int checks = 0;

    logic [19:0] rom [4];

    initial begin
        rom[0] = 20'd3;
        rom[1] = 20'd0;
        rom[2] = 20'd1;
        rom[3] = 20'd7;
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data    <= rom[rom_addr[1:0]];
        rom_data_ng <= rom[rom_addr_ng[1:0]];
    end

    music_player #(.NUM_NOTES(3), .NOTE_TICKS(20), .GAP_TICKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_data(rom_data), .speaker(speaker), .busy(busy), .done(done)
    );

    music_player #(.NUM_NOTES(3), .NOTE_TICKS(20), .GAP_TICKS(0)) dut_ng (
        .clk(clk), .rst_n(rst_n), .start(start_ng), .stop(1'b0), .loop(loop_ng),
        .rom_addr(rom_addr_ng), .rom_data(rom_data_ng), .speaker(speaker_ng),
        .busy(busy_ng), .done(done_ng)
    );

    function automatic int hp_of(input int slot);
        case (slot % 3)
            0:       return 3;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    // Expected speaker at slot offset o (0 FETCH, 1 LOAD, then PLAY, then GAP)
    function automatic logic exp_spk(input int hp, input int o, input int play_len);
        int p;
        if (o < 2 || o >= 2 + play_len || hp == 0) return 1'b0;
        p = o - 2;
        return ((p / hp) % 2) == 1;
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker: got %b want 0", speaker); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_play;
        int i, slot, o;
        loop = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            i = c - 1; slot = i / Slot; o = i % Slot;
            if (c <= 66) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy c=%0d: got %b want 1", c, busy); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done c=%0d: got %b want 0", c, done); end
                checks++; if (rom_addr !== 5'(slot)) begin errors++; $display("FAIL single_addr c=%0d: got %0d want %0d", c, rom_addr, slot); end
                checks++; if (speaker !== exp_spk(hp_of(slot), o, PlayLen)) begin
                    errors++; $display("FAIL single_speaker c=%0d: got %b want %b", c, speaker, exp_spk(hp_of(slot), o, PlayLen));
                end
            end else if (c == 67) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b want 1", done); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_finish_busy: got %b want 1", busy); end
                checks++; if (rom_addr !== 5'd2) begin errors++; $display("FAIL single_finish_addr: got %0d want 2", rom_addr); end
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_after: got %b want 0", done); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
                checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL single_addr_after: got %0d want 0", rom_addr); end
            end
            next_cycle();
        end
    endtask

    task automatic test_loop;
        int i, slot, o;
        loop = 1'b1;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 134; c++) begin
            if (c == 96) loop = 1'b0;
            i = c - 1; slot = i / Slot; o = i % Slot;
            if (c <= 132) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done c=%0d: got %b want 0", c, done); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy c=%0d: got %b want 1", c, busy); end
                checks++; if (rom_addr !== 5'(slot % 3)) begin errors++; $display("FAIL loop_addr c=%0d: got %0d want %0d", c, rom_addr, slot % 3); end
                checks++; if (speaker !== exp_spk(hp_of(slot), o, PlayLen)) begin
                    errors++; $display("FAIL loop_speaker c=%0d: got %b want %b", c, speaker, exp_spk(hp_of(slot), o, PlayLen));
                end
            end else if (c == 133) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL loop_done_pulse: got %b want 1", done); end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_after: got %b want 0", busy); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done_after: got %b want 0", done); end
            end
            next_cycle();
        end
    endtask

    task automatic test_stop;
        loop = 1'b0;
        // stop during note 1 PLAY
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 28; c++) next_cycle();
        checks++; if (rom_addr !== 5'd1) begin errors++; $display("FAIL stop_pre_addr: got %0d want 1", rom_addr); end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL stop_speaker: got %b want 0", speaker); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL stop_addr: got %0d want 0", rom_addr); end
        for (int c = 0; c < 80; c++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL stop_quiet c=%0d: got done=%b busy=%b want 0 0", c, done, busy);
            end
            next_cycle();
        end
        // stop while the speaker is high during note 0
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 6; c++) next_cycle();
        checks++; if (speaker !== 1'b1) begin errors++; $display("FAIL stop_high_pre: got %b want 1", speaker); end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL stop_high_speaker: got %b want 0", speaker); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_high_busy: got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_conflicts;
        int i, slot;
        start = 1'b1;
        stop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conflict_busy c=%0d: got %b want 0", c, busy); end
        end
        start = 1'b0;
        stop = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            start = (c == 10 || c == 45 || c == 67);
            i = c - 1; slot = i / Slot;
            if (c <= 66) begin
                checks++; if (rom_addr !== 5'(slot) || busy !== 1'b1) begin
                    errors++; $display("FAIL restart_addr c=%0d: got addr=%0d busy=%b want %0d 1", c, rom_addr, busy, slot);
                end
            end else if (c == 67) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_after_finish: got busy=%b want 0", busy); end
            end
            next_cycle();
        end
        start = 1'b0;
        next_cycle();
    endtask

    task automatic test_async_reset;
        int o;
        loop = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c < 64; c++) next_cycle();
        checks++; if (busy !== 1'b1 || rom_addr !== 5'd2) begin
            errors++; $display("FAIL areset_pre: got busy=%b addr=%0d want 1 2", busy, rom_addr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL areset_addr: got %0d want 0", rom_addr); end
        checks++; if (speaker !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL areset_spk_done: got %b %b want 0 0", speaker, done);
        end
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            o = (c - 1) % Slot;
            checks++; if (rom_addr !== ((c <= 22) ? 5'd0 : 5'd1)) begin
                errors++; $display("FAIL areset_replay_addr c=%0d: got %0d", c, rom_addr);
            end
            checks++; if (speaker !== exp_spk((c <= 22) ? 3 : 0, o, PlayLen)) begin
                errors++; $display("FAIL areset_replay_speaker c=%0d: got %b", c, speaker);
            end
            next_cycle();
        end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        next_cycle();
    endtask

    task automatic test_no_gap;
        int i, slot, o;
        loop_ng = 1'b0;
        start_ng = 1'b1;
        next_cycle();
        start_ng = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            i = c - 1; slot = i / Slot; o = i % Slot;
            if (c <= 66) begin
                checks++; if (rom_addr_ng !== 5'(slot) || busy_ng !== 1'b1) begin
                    errors++; $display("FAIL nogap_addr c=%0d: got addr=%0d busy=%b want %0d 1", c, rom_addr_ng, busy_ng, slot);
                end
                checks++; if (speaker_ng !== exp_spk(hp_of(slot), o, PlayLen2)) begin
                    errors++; $display("FAIL nogap_speaker c=%0d: got %b want %b", c, speaker_ng, exp_spk(hp_of(slot), o, PlayLen2));
                end
            end else if (c == 67) begin
                checks++; if (done_ng !== 1'b1) begin errors++; $display("FAIL nogap_done: got %b want 1", done_ng); end
            end else begin
                checks++; if (busy_ng !== 1'b0 || done_ng !== 1'b0) begin
                    errors++; $display("FAIL nogap_after: got busy=%b done=%b want 0 0", busy_ng, done_ng);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_play();
        test_loop();
        test_stop();
        test_conflicts();
        test_async_reset();
        test_no_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
